// File: rtl/mlp_pkg.sv
// Shared widths, FSM state type and weight multiply for the MLP stream core.
package mlp_pkg;

    typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} st_e;

    function automatic int mlp_d1(input int n1);
        return $clog2(n1 / 2);
    endfunction

    function automatic int mlp_d2(input int n2);
        return $clog2(n2);
    endfunction

    function automatic int mlp_wh(input int n1, input int wx, input int wk);
        return wx + wk + mlp_d1(n1) + 1;
    endfunction

    function automatic int mlp_wy(input int n1, input int n2, input int wx, input int wk);
        return mlp_wh(n1, wx, wk) + wk + mlp_d2(n2);
    endfunction

    function automatic int mlp_lat(input int n1, input int n2);
        return mlp_d1(n1) + mlp_d2(n2) + 3;
    endfunction

    // A one-bit weight is binary: 0 means +1, 1 means -1.
    function automatic logic signed [63:0] mlp_mul(input logic [31:0] k, input int wk,
                                                   input logic signed [63:0] x);
        logic signed [63:0] ks;
        if (wk == 1)
            ks = k[0] ? -64'sd1 : 64'sd1;
        else
            ks = $signed(64'(k) << (64 - wk)) >>> (64 - wk);
        return ks * x;
    endfunction

endpackage

// File: rtl/mlp_stream_if.sv
// Weight, sample and result streams of the MLP core; master drives, slave is the core.
interface mlp_stream_if import mlp_pkg::*; #(
    parameter int N1  = 98,
    parameter int N2  = 20,
    parameter int W_X = 4,
    parameter int W_K = 4
);
    localparam int W_Y = mlp_wy(N1, N2, W_X, W_K);

    logic                    w_start;
    logic                    w_valid;
    logic                    w_ready;
    logic [W_K-1:0]          w_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [N1/2*W_X-1:0]     in_mag;
    logic [N1/2-1:0]         in_pol;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [W_Y-1:0]   out_data;
    logic                    wt_ok;

    modport master (
        output w_start, w_valid, w_data, in_valid, in_mag, in_pol, out_ready,
        input  w_ready, in_ready, out_valid, out_data, wt_ok
    );

    modport slave (
        input  w_start, w_valid, w_data, in_valid, in_mag, in_pol, out_ready,
        output w_ready, in_ready, out_valid, out_data, wt_ok
    );
endinterface

// File: rtl/mlp_add_tree.sv
// Pipelined signed adder tree reducing N operands to one sign-extended sum.
// Latency: $clog2(N) cycles (combinational pass-through when N==1).
// Backpressure: every level holds while en is low.
module mlp_add_tree #(
    parameter int N     = 4,
    parameter int W_IN  = 8,
    parameter int W_OUT = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [W_IN-1:0]  din [N],
    output logic signed [W_OUT-1:0] dout
);
    localparam int L  = (N > 1) ? $clog2(N) : 0;
    localparam int P  = 1 << L;
    localparam int LS = (L > 0) ? L : 1;

    logic signed [W_OUT-1:0] lv0 [P];
    logic signed [W_OUT-1:0] st  [LS][P];

    // Odd-sized levels are padded with zero operands up to a power of two.
    for (genvar i = 0; i < P; i++) begin : g_pad
        if (i < N) begin : g_d
            assign lv0[i] = W_OUT'(din[i]);
        end else begin : g_z
            assign lv0[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LS; l++)
                for (int i = 0; i < P; i++)
                    st[l][i] <= '0;
        end else if (en) begin
            for (int i = 0; i < P / 2; i++)
                st[0][i] <= lv0[2*i] + lv0[2*i+1];
            for (int l = 1; l < L; l++)
                for (int i = 0; i < (P >> (l + 1)); i++)
                    st[l][i] <= st[l-1][2*i] + st[l-1][2*i+1];
        end
    end

    if (L == 0) begin : g_pass
        assign dout = lv0[0];
    end else begin : g_out
        assign dout = st[L-1][0];
    end
endmodule

// File: rtl/mlp_stream.sv
// Two-layer MLP denoiser core with runtime weight load; MLP_RELU_EN clamps hidden sums at zero.
// Latency: D1+D2+3 cycles from accept to out_valid, one sample per cycle.
// Backpressure: whole pipe stalls while out_valid & !out_ready; in_ready follows the stall.
module mlp_stream import mlp_pkg::*; #(
    parameter int N1  = 98,
    parameter int N2  = 20,
    parameter int W_X = 4,
    parameter int W_K = 4
) (
    input  logic        clk,
    input  logic        rst,
    mlp_stream_if.slave io
);
    localparam int H    = N1 / 2;
    localparam int W_H  = mlp_wh(N1, W_X, W_K);
    localparam int W_Y  = mlp_wy(N1, N2, W_X, W_K);
    localparam int LAT  = mlp_lat(N1, N2);
    localparam int W_P  = W_X + W_K + 1;
    localparam int W_P2 = W_H + W_K;
    localparam int NW   = N1 * N2 + N2;
    localparam int AW   = $clog2(NW);

    st_e              st;
    logic [AW-1:0]    addr;
    logic             wt_ok_q;
    logic             w_ready_q;
    logic [W_K-1:0]   wmem [NW];
    logic [LAT-1:0]   vld;
    logic             en;
    logic             acc;
    logic             wr_en;

    assign en           = !vld[LAT-1] | io.out_ready;
    assign io.in_ready  = (st == RUN) & en;
    assign acc          = io.in_valid & io.in_ready;
    assign io.out_valid = vld[LAT-1];
    assign io.w_ready   = w_ready_q;
    assign io.wt_ok     = wt_ok_q;
    assign wr_en        = (st == LOAD) & io.w_valid & !io.w_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= EMPTY;
            addr      <= '0;
            wt_ok_q   <= 1'b0;
            w_ready_q <= 1'b0;
        end else begin
            case (st)
                EMPTY: if (io.w_start) begin
                    st        <= LOAD;
                    w_ready_q <= 1'b1;
                    addr      <= '0;
                end
                LOAD: if (io.w_start) begin
                    addr <= '0;
                end else if (io.w_valid) begin
                    if (addr == AW'(NW - 1)) begin
                        st        <= RUN;
                        wt_ok_q   <= 1'b1;
                        w_ready_q <= 1'b0;
                        addr      <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                RUN: if (io.w_start) begin
                    st      <= DRAIN;
                    wt_ok_q <= 1'b0;
                end
                // Old-weight tokens must leave before any weight is overwritten.
                DRAIN: if (!(|vld)) begin
                    st        <= LOAD;
                    w_ready_q <= 1'b1;
                end
                default: st <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            wmem[addr] <= io.w_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld <= '0;
        else if (en)
            vld <= {vld[LAT-2:0], acc};
    end

    logic signed [W_P-1:0] pm_q [N2][H];
    logic signed [W_P-1:0] pp_q [N2][H];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N2; n++)
                for (int i = 0; i < H; i++) begin
                    pm_q[n][i] <= '0;
                    pp_q[n][i] <= '0;
                end
        end else if (en) begin
            for (int n = 0; n < N2; n++)
                for (int i = 0; i < H; i++) begin
                    pm_q[n][i] <= W_P'(mlp_mul(32'(wmem[n*N1+i]), W_K,
                                               64'(io.in_mag[i*W_X +: W_X])));
                    pp_q[n][i] <= W_P'(mlp_mul(32'(wmem[n*N1+H+i]), W_K,
                                               64'(io.in_pol[i])));
                end
        end
    end

    logic signed [W_H-1:0] ms [N2];
    logic signed [W_H-1:0] ps [N2];

    for (genvar n = 0; n < N2; n++) begin : g_l1
        mlp_add_tree #(.N(H), .W_IN(W_P), .W_OUT(W_H)) u_mag (
            .clk(clk), .rst(rst), .en(en), .din(pm_q[n]), .dout(ms[n])
        );
        mlp_add_tree #(.N(H), .W_IN(W_P), .W_OUT(W_H)) u_pol (
            .clk(clk), .rst(rst), .en(en), .din(pp_q[n]), .dout(ps[n])
        );
    end

    logic signed [W_H-1:0]  h_d  [N2];
    logic signed [W_H-1:0]  h_q  [N2];
    logic signed [W_P2-1:0] p2_q [N2];

    always_comb begin
        for (int n = 0; n < N2; n++) begin
            h_d[n] = ms[n] + ps[n];
`ifdef MLP_RELU_EN
            if (h_d[n] < 0)
                h_d[n] = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N2; n++) begin
                h_q[n]  <= '0;
                p2_q[n] <= '0;
            end
        end else if (en) begin
            for (int n = 0; n < N2; n++) begin
                h_q[n]  <= h_d[n];
                p2_q[n] <= W_P2'(mlp_mul(32'(wmem[N1*N2+n]), W_K, 64'(h_q[n])));
            end
        end
    end

    mlp_add_tree #(.N(N2), .W_IN(W_P2), .W_OUT(W_Y)) u_l2 (
        .clk(clk), .rst(rst), .en(en), .din(p2_q), .dout(io.out_data)
    );
endmodule

// File: tb/tb_mlp_stream.sv
// Directed bench for mlp_stream with N1=8, N2=4, W_X=4, W_K=4 (latency 7).
module tb_mlp_stream;
    import mlp_pkg::*;

    localparam int N1  = 8;
    localparam int N2  = 4;
    localparam int W_X = 4;
    localparam int W_K = 4;
    localparam int H   = N1 / 2;
    localparam int W_Y = 17;
    localparam int LAT = 7;
    localparam int NW  = N1 * N2 + N2;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    mlp_stream_if #(.N1(N1), .N2(N2), .W_X(W_X), .W_K(W_K)) io ();

    mlp_stream #(.N1(N1), .N2(N2), .W_X(W_X), .W_K(W_K)) dut (
        .clk(clk), .rst(rst), .io(io)
    );

    task automatic set_inputs(input logic [W_X-1:0] m, input logic p);
        for (int i = 0; i < H; i++)
            io.in_mag[i*W_X +: W_X] = m;
        io.in_pol = {H{p}};
    endtask

    task automatic load_w(input logic [W_K-1:0] l1, input logic [W_K-1:0] l2);
        int   i = 0;
        int   g = 0;
        logic rdy;
        @(posedge clk); #1 io.w_start = 1'b1;
        @(posedge clk); #1 io.w_start = 1'b0;
        while (i < NW && g < 2000) begin
            io.w_valid = 1'b1;
            io.w_data  = (i < N1 * N2) ? l1 : l2;
            rdy = io.w_ready;
            @(posedge clk); #1;
            g++;
            if (rdy) i++;
        end
        io.w_valid = 1'b0;
    endtask

    task automatic run_sample(input logic [W_X-1:0] m, input logic p,
                              output logic signed [W_Y-1:0] res, output int cyc);
        int g = 0;
        set_inputs(m, p);
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        while (!io.in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        cyc = 1;
        while (!io.out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = io.out_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_tot++; if (io.wt_ok !== 1'b0) $display("FAIL reset_wt_ok: got %b want 0", io.wt_ok); else n_pass++;
        n_tot++; if (io.w_ready !== 1'b0) $display("FAIL reset_w_ready: got %b want 0", io.w_ready); else n_pass++;
        n_tot++; if (io.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", io.in_ready); else n_pass++;
        n_tot++; if (io.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", io.out_valid); else n_pass++;
        n_tot++; if (io.out_data !== 17'sd0) $display("FAIL reset_out_data: got %0d want 0", io.out_data); else n_pass++;
    endtask

    task automatic test_ones();
        logic signed [W_Y-1:0] r;
        int c;
        load_w(4'd1, 4'd1);
        n_tot++; if (io.wt_ok !== 1'b1) $display("FAIL ones_wt_ok: got %b want 1", io.wt_ok); else n_pass++;
        run_sample(4'd1, 1'b0, r, c);
        n_tot++; if (r !== 17'sd16) $display("FAIL ones_mag_data: got %0d want 16", r); else n_pass++;
        n_tot++; if (c !== LAT) $display("FAIL ones_mag_latency: got %0d want %0d", c, LAT); else n_pass++;
        run_sample(4'd1, 1'b1, r, c);
        n_tot++; if (r !== 17'sd32) $display("FAIL ones_pol_data: got %0d want 32", r); else n_pass++;
        n_tot++; if (c !== LAT) $display("FAIL ones_pol_latency: got %0d want %0d", c, LAT); else n_pass++;
    endtask

    task automatic test_mixed();
        logic signed [W_Y-1:0] r;
        int c;
        // Hidden = 4*(2*5) + 4*(2*1) = 48 per neuron; output = 4 * (-3 * 48).
        load_w(4'd2, 4'hD);
        run_sample(4'd5, 1'b1, r, c);
        n_tot++; if (r !== -17'sd576) $display("FAIL mixed_signed_l2: got %0d want -576", r); else n_pass++;
    endtask

    task automatic test_relu();
        logic signed [W_Y-1:0] r;
        logic signed [W_Y-1:0] e1;
        logic signed [W_Y-1:0] e2;
        int c;
`ifdef MLP_RELU_EN
        e1 = 17'sd0;
        e2 = 17'sd0;
`else
        e1 = -17'sd16;
        e2 = -17'sd64;
`endif
        load_w(4'hF, 4'd1);
        n_tot++; if (io.wt_ok !== 1'b1) $display("FAIL relu_wt_ok: got %b want 1", io.wt_ok); else n_pass++;
        run_sample(4'd1, 1'b0, r, c);
        n_tot++; if (r !== e1) $display("FAIL relu_neg_mag: got %0d want %0d", r, e1); else n_pass++;
        run_sample(4'd3, 1'b1, r, c);
        n_tot++; if (r !== e2) $display("FAIL relu_neg_mag_pol: got %0d want %0d", r, e2); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic signed [W_Y-1:0] exp_q [10];
        logic signed [W_Y-1:0] held_val;
        logic held = 1'b0;
        int got = 0;
        int cyc = 0;
        for (int i = 0; i < 10; i++)
            exp_q[i] = W_Y'(16 * (i + 1) + 16 * (i % 2));
        load_w(4'd1, 4'd1);
        io.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic a;
                    int   g;
                    a = 1'b0;
                    g = 0;
                    set_inputs(W_X'(i + 1), i[0]);
                    io.in_valid = 1'b1;
                    while (!a && g < 300) begin
                        @(negedge clk); #3;
                        a = io.in_ready;
                        @(posedge clk); #1;
                        g++;
                    end
                end
                io.in_valid = 1'b0;
            end
            begin
                while (got < 10 && cyc < 300) begin
                    @(negedge clk);
                    io.out_ready = !(cyc >= 9 && cyc < 14);
                    #1;
                    if (held) begin
                        n_tot++;
                        if (io.out_valid !== 1'b1 || io.out_data !== held_val)
                            $display("FAIL b2b_stall_hold: got v=%b d=%0d want v=1 d=%0d", io.out_valid, io.out_data, held_val);
                        else n_pass++;
                    end
                    held = 1'b0;
                    if (io.out_valid) begin
                        if (io.out_ready) begin
                            n_tot++;
                            if (io.out_data !== exp_q[got])
                                $display("FAIL b2b_order[%0d]: got %0d want %0d", got, io.out_data, exp_q[got]);
                            else n_pass++;
                            got++;
                        end else begin
                            held     = 1'b1;
                            held_val = io.out_data;
                        end
                    end
                    cyc++;
                end
            end
        join
        io.out_ready = 1'b1;
        n_tot++; if (got !== 10) $display("FAIL b2b_count: got %0d want 10", got); else n_pass++;
        repeat (12) @(posedge clk);
        #1;
        n_tot++; if (io.out_valid !== 1'b0) $display("FAIL b2b_no_extra: got %b want 0", io.out_valid); else n_pass++;
    endtask

    task automatic test_reload_in_flight();
        logic signed [W_Y-1:0] exp3 [3];
        logic signed [W_Y-1:0] r;
        int got = 0;
        int g = 0;
        int c;
        exp3[0] = 17'sd16;
        exp3[1] = 17'sd32;
        exp3[2] = 17'sd48;
        io.out_ready = 1'b1;
        set_inputs(4'd1, 1'b0);
        io.in_valid = 1'b1;
        @(posedge clk); #1 set_inputs(4'd2, 1'b0);
        @(posedge clk); #1 set_inputs(4'd3, 1'b0);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.w_start  = 1'b1;
        @(posedge clk); #1;
        io.w_start = 1'b0;
        n_tot++; if (io.in_ready !== 1'b0) $display("FAIL drain_in_ready: got %b want 0", io.in_ready); else n_pass++;
        n_tot++; if (io.wt_ok !== 1'b0) $display("FAIL drain_wt_ok: got %b want 0", io.wt_ok); else n_pass++;
        while (got < 3 && g < 50) begin
            if (io.out_valid) begin
                n_tot++;
                if (io.out_data !== exp3[got])
                    $display("FAIL drain_old_result[%0d]: got %0d want %0d", got, io.out_data, exp3[got]);
                else n_pass++;
                got++;
            end
            @(posedge clk); #1;
            g++;
        end
        n_tot++; if (got !== 3) $display("FAIL drain_count: got %0d want 3", got); else n_pass++;
        g = 0;
        while (!io.w_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        n_tot++; if (io.w_ready !== 1'b1) $display("FAIL drain_to_load: got %b want 1", io.w_ready); else n_pass++;
        load_w(4'd2, 4'd2);
        n_tot++; if (io.wt_ok !== 1'b1) $display("FAIL reload_wt_ok: got %b want 1", io.wt_ok); else n_pass++;
        run_sample(4'd1, 1'b0, r, c);
        n_tot++; if (r !== 17'sd64) $display("FAIL reload_data: got %0d want 64", r); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        logic signed [W_Y-1:0] r;
        int c;
        int g = 0;
        @(posedge clk); #1 io.w_start = 1'b1;
        @(posedge clk); #1 io.w_start = 1'b0;
        while (!io.w_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        io.w_valid = 1'b1;
        io.w_data  = 4'd5;
        repeat (5) @(posedge clk);
        #1 io.w_valid = 1'b0;
        n_tot++; if (io.wt_ok !== 1'b0) $display("FAIL partial_wt_ok: got %b want 0", io.wt_ok); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_tot++; if (io.wt_ok !== 1'b0) $display("FAIL midrst_wt_ok: got %b want 0", io.wt_ok); else n_pass++;
        n_tot++; if (io.w_ready !== 1'b0) $display("FAIL midrst_w_ready: got %b want 0", io.w_ready); else n_pass++;
        n_tot++; if (io.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", io.in_ready); else n_pass++;
        n_tot++; if (io.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", io.out_valid); else n_pass++;
        load_w(4'd1, 4'd1);
        n_tot++; if (io.wt_ok !== 1'b1) $display("FAIL midrst_reload_wt_ok: got %b want 1", io.wt_ok); else n_pass++;
        run_sample(4'd1, 1'b0, r, c);
        n_tot++; if (r !== 17'sd16) $display("FAIL midrst_reload_data: got %0d want 16", r); else n_pass++;
        n_tot++; if (c !== LAT) $display("FAIL midrst_reload_latency: got %0d want %0d", c, LAT); else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        io.w_start   = 1'b0;
        io.w_valid   = 1'b0;
        io.w_data    = '0;
        io.in_valid  = 1'b0;
        io.in_mag    = '0;
        io.in_pol    = '0;
        io.out_ready = 1'b1;
        test_reset();
        test_ones();
        test_mixed();
        test_relu();
        test_back_to_back();
        test_reload_in_flight();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks passed", n_pass, n_tot);
        $fatal(1);
    end
endmodule
